wb_mem_stage: RTL and testbench
===============================

Name: wb_mem_stage

Overview:
- Consumer end of the issue buffer's result interface. Takes the four per-cycle result lanes, the lane-1 memory address and the load/store flags.
- Writes ALU results to the register file one cycle later.
- Runs a single-outstanding data-memory transaction for lane-1 loads and stores, and returns mem_in_done to the buffer.
- Reports every register written each cycle so RAW history bits can be cleared.

Parameters:
des, 4, destination register index width
reg_num, 16, register count (= 2**des)
register_width, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_k_des (k=1..4)  in  des  lane k destination
in_k_data (k=1..4)  in  register_width  lane k ALU result; lane 1 carries store data when in_store_flag=1
in_k_vld (k=1..4)  in  1  lane k valid
in_mem_addr  in  register_width  lane-1 memory address
in_load_flag  in  1  lane 1 is a load
in_store_flag  in  1  lane 1 is a store
mem_in_done  out  1  one-cycle pulse when a memory op completes
mem_busy  out  1  memory FSM not IDLE; upstream must not issue a memory op
dmem_req  out  1  memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  register_width  request address
dmem_wdata  out  register_width  store data
dmem_ack  in  1  memory accepted/completed the request
dmem_rdata  in  register_width  load data, valid with dmem_ack
wb_k_en (k=1..4)  out  1  register-file write enable, port k
wb_k_addr (k=1..4)  out  des  write address, port k
wb_k_data (k=1..4)  out  register_width  write data, port k
raw_clear  out  reg_num  bit r = 1 if register r is written this cycle

Behaviour:
Reset:
- All outputs, FSM and pipeline registers go to 0 / IDLE.
- A reset mid-transaction drops dmem_req the next cycle and produces no mem_in_done and no writeback.

ALU path:
- A lane is an ALU op if in_k_vld=1, except lane 1 when either flag is set.
- An ALU op is registered and drives wb_k_en/addr/data the next cycle (latency 1).

Same-cycle destination collisions:
- A higher-numbered lane is younger and wins.
- When two enabled ports carry equal addr, the lower-numbered port's en is forced to 0.

raw_clear:
- OR of one-hot(wb_k_addr) over all enabled ports, same cycle as the write.

Memory FSM (IDLE, REQ, LDWB, DONE):
- IDLE: when in_1_vld and (load or store), capture address, des and data, then go to REQ.
  - If both flags are set, the op is treated as a load.
- REQ: dmem_req=1; dmem_we=1 for a store.
  - Address and data are held stable until dmem_ack.
  - On ack: a load captures dmem_rdata and goes to LDWB; a store goes to DONE.
  - An ack in the first REQ cycle is legal.
  - dmem_req is 0 in the cycle after ack.
- LDWB: write the load via port 1 only if the ALU lane-1 port is idle this cycle; otherwise stay in LDWB (stall).
  - If any enabled ALU port writes the same des that cycle, the load write is suppressed (the younger op wins) and the FSM proceeds.
  - On write or suppression, go to DONE.
- DONE: mem_in_done=1 for exactly one cycle, then go to IDLE.
- mem_busy=1 in REQ, LDWB and DONE.
- A memory op presented while mem_busy=1 is ignored: no state change, no writeback.
- ALU lanes 2–4 accepted in that same cycle still write back normally.
- ALU traffic on all lanes keeps flowing while the FSM is busy.

Widths:
- No arithmetic on data; the address passes through unchanged.
- raw_clear is exactly reg_num bits.

Test Plan:
- Reset: hold rst 2 cycles with inputs toggling → every output 0, FSM IDLE; release, no spurious wb_k_en or mem_in_done.
- ALU burst: lanes 1–4 valid, des 1/2/3/4, data 0x11/0x22/0x33/0x44 → next cycle all wb_k_en=1 with matching addr/data, raw_clear=0x001E.
- Collision: lane2 des5 data 0xA, lane4 des5 data 0xB → wb_2_en=0, wb_4_en=1 with data 0xB, raw_clear=0x0020.
- Load: lane 1, in_load_flag=1, addr 0x100, des 7; dmem_ack on 3rd REQ cycle with rdata 0xDEADBEEF → dmem_req high 3 cycles, dmem_we=0; next cycle wb_1 writes r7=0xDEADBEEF with raw_clear=0x0080; following cycle mem_in_done=1 for 1 cycle.
- Store + stall: store addr 0x40 data 0x55, ack after 1 cycle → dmem_we=1, no wb_k_en for the store, single mem_in_done pulse.
  - Separately, a load reaches LDWB while ALU lane 1 writes r3 → load written one cycle later.
  - If that ALU write targets the load's des instead, only the ALU value is written.
- Reset mid-REQ, plus a second memory op issued while mem_busy → dmem_req low the next cycle, no mem_in_done; the ignored op never appears on dmem_*.

Source files
------------

// File: rtl/wb_mem_stage.sv
// Writeback/memory stage: registers four ALU result lanes onto register-file write
// ports and runs a single outstanding lane-1 load/store against the data memory.

module wb_mem_lane #(
   parameter int des            = 4,
   parameter int register_width = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_vld,
   input  logic [des-1:0]            in_des,
   input  logic [register_width-1:0] in_data,
   output logic                      en_q,
   output logic [des-1:0]            addr_q,
   output logic [register_width-1:0] data_q
);
   logic                      en_d;
   logic [des-1:0]            addr_d;
   logic [register_width-1:0] data_d;

   always_comb begin
      en_d   = in_vld;
      addr_d = in_des;
      data_d = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         en_q   <= en_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end
endmodule

module wb_mem_stage #(
   parameter int des            = 4,
   parameter int reg_num        = 16,
   parameter int register_width = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [des-1:0]            in_1_des,
   input  logic [des-1:0]            in_2_des,
   input  logic [des-1:0]            in_3_des,
   input  logic [des-1:0]            in_4_des,
   input  logic [register_width-1:0] in_1_data,
   input  logic [register_width-1:0] in_2_data,
   input  logic [register_width-1:0] in_3_data,
   input  logic [register_width-1:0] in_4_data,
   input  logic                      in_1_vld,
   input  logic                      in_2_vld,
   input  logic                      in_3_vld,
   input  logic                      in_4_vld,
   input  logic [register_width-1:0] in_mem_addr,
   input  logic                      in_load_flag,
   input  logic                      in_store_flag,
   output logic                      mem_in_done,
   output logic                      mem_busy,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [register_width-1:0] dmem_addr,
   output logic [register_width-1:0] dmem_wdata,
   input  logic                      dmem_ack,
   input  logic [register_width-1:0] dmem_rdata,
   output logic                      wb_1_en,
   output logic                      wb_2_en,
   output logic                      wb_3_en,
   output logic                      wb_4_en,
   output logic [des-1:0]            wb_1_addr,
   output logic [des-1:0]            wb_2_addr,
   output logic [des-1:0]            wb_3_addr,
   output logic [des-1:0]            wb_4_addr,
   output logic [register_width-1:0] wb_1_data,
   output logic [register_width-1:0] wb_2_data,
   output logic [register_width-1:0] wb_3_data,
   output logic [register_width-1:0] wb_4_data,
   output logic [reg_num-1:0]        raw_clear
);
   localparam int NUM_LANES = 4;
   typedef enum logic [1:0] {IDLE, REQ, LDWB, DONE} state_t;

   logic                                     mem_op;
   logic [NUM_LANES-1:0]                     lane_vld;
   logic [NUM_LANES-1:0][des-1:0]            lane_des;
   logic [NUM_LANES-1:0][register_width-1:0] lane_data;
   logic [NUM_LANES-1:0]                     alu_en_q;
   logic [NUM_LANES-1:0][des-1:0]            alu_addr_q;
   logic [NUM_LANES-1:0][register_width-1:0] alu_data_q;
   logic [NUM_LANES-1:0]                     p_en, wb_en;
   logic [NUM_LANES-1:0][des-1:0]            p_addr;
   logic [NUM_LANES-1:0][register_width-1:0] p_data;

   state_t                    state_q, state_d;
   logic [register_width-1:0] maddr_q, maddr_d, mdata_q, mdata_d;
   logic [des-1:0]            mdes_q, mdes_d;
   logic                      mwe_q, mwe_d;
   logic                      load_hit, load_wr;

   assign mem_op    = in_load_flag | in_store_flag;
   assign lane_vld  = {in_4_vld, in_3_vld, in_2_vld, in_1_vld & ~mem_op};
   assign lane_des  = {in_4_des, in_3_des, in_2_des, in_1_des};
   assign lane_data = {in_4_data, in_3_data, in_2_data, in_1_data};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      wb_mem_lane #(.des(des), .register_width(register_width)) u_lane (
         .clk(clk), .rst(rst), .in_vld(lane_vld[g]), .in_des(lane_des[g]), .in_data(lane_data[g]),
         .en_q(alu_en_q[g]), .addr_q(alu_addr_q[g]), .data_q(alu_data_q[g])
      );
   end

   // A younger ALU write to the load's destination makes the load result dead.
   always_comb begin
      load_hit = 1'b0;
      for (int k = 0; k < NUM_LANES; k++)
         if (alu_en_q[k] && alu_addr_q[k] == mdes_q) load_hit = 1'b1;
      load_wr = (state_q == LDWB) && !load_hit && !alu_en_q[0];
   end

   always_comb begin
      p_en   = alu_en_q;
      p_addr = alu_addr_q;
      p_data = alu_data_q;
      if (load_wr) begin
         p_en[0]   = 1'b1;
         p_addr[0] = mdes_q;
         p_data[0] = mdata_q;
      end
      wb_en     = p_en;
      raw_clear = '0;
      for (int k = 0; k < NUM_LANES; k++)
         for (int j = k + 1; j < NUM_LANES; j++)
            if (p_en[j] && p_addr[j] == p_addr[k]) wb_en[k] = 1'b0;
      for (int k = 0; k < NUM_LANES; k++)
         if (wb_en[k]) raw_clear[p_addr[k]] = 1'b1;
   end

   assign {wb_4_en, wb_3_en, wb_2_en, wb_1_en} = wb_en;
   assign {wb_4_addr, wb_3_addr, wb_2_addr, wb_1_addr} = p_addr;
   assign {wb_4_data, wb_3_data, wb_2_data, wb_1_data} = p_data;

   always_comb begin
      state_d = state_q;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
      mdes_d  = mdes_q;
      mwe_d   = mwe_q;
      case (state_q)
         IDLE: if (in_1_vld && mem_op) begin
            state_d = REQ;
            maddr_d = in_mem_addr;
            mdata_d = in_1_data;
            mdes_d  = in_1_des;
            mwe_d   = ~in_load_flag;   // both flags set -> load
         end
         REQ: if (dmem_ack) begin
            if (mwe_q) state_d = DONE;
            else begin
               state_d = LDWB;
               mdata_d = dmem_rdata;
            end
         end
         LDWB:    if (load_hit || !alu_en_q[0]) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         maddr_q <= '0;
         mdata_q <= '0;
         mdes_q  <= '0;
         mwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         mdes_q  <= mdes_d;
         mwe_q   <= mwe_d;
      end
   end

   assign dmem_req    = (state_q == REQ);
   assign dmem_we     = dmem_req & mwe_q;
   assign dmem_addr   = dmem_req ? maddr_q : '0;
   assign dmem_wdata  = dmem_we ? mdata_q : '0;
   assign mem_in_done = (state_q == DONE);
   assign mem_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_wb_mem_stage.sv
// Self-checking bench for wb_mem_stage: directed scenarios plus randomized traffic
// against a register-file level reference model.

module tb_wb_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  i_des [4];
   logic [31:0] i_data [4];
   logic [3:0]  i_vld;
   logic [31:0] in_mem_addr;
   logic        in_load_flag, in_store_flag;
   logic        mem_in_done, mem_busy, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  wb_en;
   logic [3:0]  wb_addr [4];
   logic [31:0] wb_data [4];
   logic [15:0] raw_clear;

   logic [31:0] rf_dut [16];
   logic [31:0] mrf [16];
   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wb_mem_stage dut (
      .clk(clk), .rst(rst),
      .in_1_des(i_des[0]), .in_2_des(i_des[1]), .in_3_des(i_des[2]), .in_4_des(i_des[3]),
      .in_1_data(i_data[0]), .in_2_data(i_data[1]), .in_3_data(i_data[2]), .in_4_data(i_data[3]),
      .in_1_vld(i_vld[0]), .in_2_vld(i_vld[1]), .in_3_vld(i_vld[2]), .in_4_vld(i_vld[3]),
      .in_mem_addr(in_mem_addr), .in_load_flag(in_load_flag), .in_store_flag(in_store_flag),
      .mem_in_done(mem_in_done), .mem_busy(mem_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_1_en(wb_en[0]), .wb_2_en(wb_en[1]), .wb_3_en(wb_en[2]), .wb_4_en(wb_en[3]),
      .wb_1_addr(wb_addr[0]), .wb_2_addr(wb_addr[1]), .wb_3_addr(wb_addr[2]), .wb_4_addr(wb_addr[3]),
      .wb_1_data(wb_data[0]), .wb_2_data(wb_data[1]), .wb_3_data(wb_data[2]), .wb_4_data(wb_data[3]),
      .raw_clear(raw_clear)
   );

   // Inputs change and outputs are sampled on the falling edge; the bench regfile absorbs writes.
   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (wb_en[k] === 1'b1) rf_dut[wb_addr[k]] = wb_data[k];
   endtask

   task automatic clear_in();
      i_vld = '0;
      for (int k = 0; k < 4; k++) begin i_des[k] = '0; i_data[k] = '0; end
      in_mem_addr = '0; in_load_flag = 1'b0; in_store_flag = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
   endtask

   // Architectural effect of this cycle's ALU lanes: younger lanes overwrite older ones.
   task automatic model_step(output logic [15:0] set);
      set = '0;
      for (int k = 0; k < 4; k++) begin
         if (i_vld[k] && !(k == 0 && (in_load_flag || in_store_flag))) begin
            mrf[i_des[k]] = i_data[k];
            set[i_des[k]] = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      logic bad;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         i_vld = 4'($urandom);
         for (int k = 0; k < 4; k++) begin i_des[k] = 4'($urandom); i_data[k] = $urandom; end
         in_mem_addr = $urandom; in_load_flag = 1'($urandom); in_store_flag = 1'($urandom);
         dmem_ack = 1'($urandom); dmem_rdata = $urandom;
         tick();
         bad = mem_in_done | mem_busy | dmem_req | dmem_we | (|dmem_addr) | (|dmem_wdata) |
               (|wb_en) | (|raw_clear);
         for (int k = 0; k < 4; k++) bad = bad | (|wb_addr[k]) | (|wb_data[k]);
         ncmp++;
         if (bad !== 1'b0) begin
            nerr++; $display("FAIL reset_outputs cyc%0d: nonzero output seen=%b required=0", c, bad);
         end
      end
      clear_in();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         ncmp++;
         if ({wb_en, mem_in_done, mem_busy} !== 6'b0) begin
            nerr++; $display("FAIL reset_release cyc%0d: en/done/busy=%b required=0", c, {wb_en, mem_in_done, mem_busy});
         end
      end
   endtask

   task automatic test_alu_burst();
      clear_in();
      i_vld = 4'hF;
      for (int k = 0; k < 4; k++) begin i_des[k] = 4'(k + 1); i_data[k] = 32'h11 * (k + 1); end
      tick();
      clear_in();
      for (int k = 0; k < 4; k++) begin
         ncmp++;
         if (wb_en[k] !== 1'b1 || wb_addr[k] !== 4'(k + 1) || wb_data[k] !== 32'h11 * (k + 1)) begin
            nerr++; $display("FAIL burst_port%0d: en=%b addr=%0d data=%h required 1/%0d/%h",
                             k + 1, wb_en[k], wb_addr[k], wb_data[k], k + 1, 32'h11 * (k + 1));
         end
      end
      ncmp++;
      if (raw_clear !== 16'h001E) begin nerr++; $display("FAIL burst_raw: got %h required 001e", raw_clear); end
      tick();
      ncmp++;
      if (wb_en !== 4'b0) begin nerr++; $display("FAIL burst_drain: wb_en=%b required 0000", wb_en); end
   endtask

   task automatic test_collision();
      clear_in();
      i_vld = 4'b1010; i_des[1] = 4'd5; i_data[1] = 32'hA; i_des[3] = 4'd5; i_data[3] = 32'hB;
      tick();
      clear_in();
      ncmp++;
      if (wb_en !== 4'b1000 || wb_addr[3] !== 4'd5 || wb_data[3] !== 32'hB) begin
         nerr++; $display("FAIL collide_2v4: en=%b addr4=%0d data4=%h required 1000/5/b", wb_en, wb_addr[3], wb_data[3]);
      end
      ncmp++;
      if (raw_clear !== 16'h0020) begin nerr++; $display("FAIL collide_raw: got %h required 0020", raw_clear); end
      i_vld = 4'hF;
      for (int k = 0; k < 3; k++) begin i_des[k] = 4'd9; i_data[k] = 32'(k); end
      i_des[3] = 4'd2; i_data[3] = 32'h2;
      tick();
      clear_in();
      ncmp++;
      if (wb_en !== 4'b1100 || wb_data[2] !== 32'd2 || raw_clear !== 16'h0204) begin
         nerr++; $display("FAIL collide_3way: en=%b data3=%h raw=%h required 1100/2/0204", wb_en, wb_data[2], raw_clear);
      end
   endtask

   task automatic test_load();
      int reqc;
      clear_in();
      i_vld = 4'b0001; in_load_flag = 1'b1; in_mem_addr = 32'h100; i_des[0] = 4'd7; i_data[0] = 32'h1234;
      tick();
      clear_in();
      reqc = 0;
      for (int c = 0; c < 10 && dmem_req === 1'b1; c++) begin
         reqc++;
         ncmp++;
         if (dmem_we !== 1'b0 || dmem_addr !== 32'h100 || mem_busy !== 1'b1) begin
            nerr++; $display("FAIL load_req: we=%b addr=%h busy=%b required 0/100/1", dmem_we, dmem_addr, mem_busy);
         end
         dmem_ack = (reqc == 3);
         dmem_rdata = (reqc == 3) ? 32'hDEADBEEF : $urandom;
         tick();
      end
      dmem_ack = 1'b0;
      ncmp++;
      if (reqc != 3) begin nerr++; $display("FAIL load_req_len: got %0d cycles required 3", reqc); end
      ncmp++;
      if (wb_en !== 4'b0001 || wb_addr[0] !== 4'd7 || wb_data[0] !== 32'hDEADBEEF ||
          raw_clear !== 16'h0080 || mem_in_done !== 1'b0) begin
         nerr++; $display("FAIL load_wb: en=%b addr=%0d data=%h raw=%h done=%b required 0001/7/deadbeef/0080/0",
                          wb_en, wb_addr[0], wb_data[0], raw_clear, mem_in_done);
      end
      tick();
      ncmp++;
      if (mem_in_done !== 1'b1 || wb_en !== 4'b0) begin
         nerr++; $display("FAIL load_done: done=%b en=%b required 1/0000", mem_in_done, wb_en);
      end
      tick();
      ncmp++;
      if (mem_in_done !== 1'b0 || mem_busy !== 1'b0) begin
         nerr++; $display("FAIL load_idle: done=%b busy=%b required 0/0", mem_in_done, mem_busy);
      end
   endtask

   task automatic test_store();
      int reqc, dones, wbs;
      clear_in();
      i_vld = 4'b0001; in_store_flag = 1'b1; in_mem_addr = 32'h40; i_des[0] = 4'd9; i_data[0] = 32'h55;
      tick();
      clear_in();
      reqc = 0; dones = 0; wbs = 0;
      for (int c = 0; c < 8; c++) begin
         if (dmem_req === 1'b1) begin
            reqc++;
            ncmp++;
            if (dmem_we !== 1'b1 || dmem_addr !== 32'h40 || dmem_wdata !== 32'h55) begin
               nerr++; $display("FAIL store_req: we=%b addr=%h wdata=%h required 1/40/55", dmem_we, dmem_addr, dmem_wdata);
            end
         end
         dmem_ack = (dmem_req === 1'b1) && (reqc == 2);
         dones += int'(mem_in_done === 1'b1);
         wbs += $countones(wb_en);
         tick();
      end
      ncmp++;
      if (reqc != 2 || dones != 1 || wbs != 0) begin
         nerr++; $display("FAIL store_seq: req=%0d done=%0d wb=%0d required 2/1/0", reqc, dones, wbs);
      end
   endtask

   task automatic test_ldwb_stall(input bit same);
      logic [3:0] ad = same ? 4'd7 : 4'd3;
      clear_in();
      i_vld = 4'b0001; in_load_flag = 1'b1; in_mem_addr = 32'h200; i_des[0] = 4'd7;
      tick();
      clear_in();
      // Ack in the first request cycle while an ALU op enters lane 1.
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
      i_vld = 4'b0001; i_des[0] = ad; i_data[0] = 32'h33;
      tick();
      clear_in();
      ncmp++;
      if (wb_en !== 4'b0001 || wb_addr[0] !== ad || wb_data[0] !== 32'h33 || dmem_req !== 1'b0) begin
         nerr++; $display("FAIL stall%0d_alu: en=%b addr=%0d data=%h req=%b required 0001/%0d/33/0",
                          same, wb_en, wb_addr[0], wb_data[0], dmem_req, ad);
      end
      tick();
      if (!same) begin
         ncmp++;
         if (wb_en !== 4'b0001 || wb_addr[0] !== 4'd7 || wb_data[0] !== 32'hCAFE0001 || mem_in_done !== 1'b0) begin
            nerr++; $display("FAIL stall_load: en=%b addr=%0d data=%h done=%b required 0001/7/cafe0001/0",
                             wb_en, wb_addr[0], wb_data[0], mem_in_done);
         end
         tick();
      end
      ncmp++;
      if (mem_in_done !== 1'b1 || wb_en !== 4'b0) begin
         nerr++; $display("FAIL stall%0d_done: done=%b en=%b required 1/0000", same, mem_in_done, wb_en);
      end
      tick();
   endtask

   task automatic test_reset_mid_req();
      int bad;
      clear_in();
      i_vld = 4'b0001; in_load_flag = 1'b1; in_mem_addr = 32'h300; i_des[0] = 4'd4;
      tick();
      clear_in();
      i_vld = 4'b0101; in_store_flag = 1'b1; in_mem_addr = 32'h999; i_des[0] = 4'd8; i_data[0] = 32'h77;
      i_des[2] = 4'd6; i_data[2] = 32'h66;
      tick();
      clear_in();
      ncmp++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h300 || dmem_we !== 1'b0 ||
          wb_en !== 4'b0100 || wb_data[2] !== 32'h66) begin
         nerr++; $display("FAIL busy_ignore: req=%b addr=%h we=%b en=%b data3=%h required 1/300/0/0100/66",
                          dmem_req, dmem_addr, dmem_we, wb_en, wb_data[2]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ncmp++;
      if (dmem_req !== 1'b0 || mem_busy !== 1'b0) begin
         nerr++; $display("FAIL midreq_reset: req=%b busy=%b required 0/0", dmem_req, mem_busy);
      end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         bad += int'(mem_in_done === 1'b1) + int'(dmem_req === 1'b1) + $countones(wb_en);
      end
      ncmp++;
      if (bad != 0) begin nerr++; $display("FAIL midreq_after: %0d stray events required 0", bad); end
   endtask

   task automatic rand_alu_lanes(input int first, input logic [3:0] avoid, input bit use_avoid);
      for (int k = first; k < 4; k++) begin
         i_vld[k] = 1'($urandom);
         i_des[k] = 4'($urandom);
         if (use_avoid && i_des[k] == avoid) i_des[k] = i_des[k] ^ 4'd1;
         i_data[k] = $urandom;
      end
   endtask

   task automatic test_random();
      logic [15:0] exp;
      logic [31:0] maddr, mdata, rdata;
      logic [3:0]  mdes;
      bit          ld;
      int          dly, reqc, dones, ldw, diff;
      for (int r = 0; r < 16; r++) begin rf_dut[r] = '0; mrf[r] = '0; end
      for (int rnd = 0; rnd < 20; rnd++) begin
         for (int c = 0; c < 8; c++) begin
            clear_in();
            rand_alu_lanes(0, 4'd0, 1'b0);
            model_step(exp);
            tick();
            ncmp++;
            if (raw_clear !== exp || $countones(wb_en) != $countones(exp)) begin
               nerr++; $display("FAIL rand_alu r%0d c%0d: raw=%h en=%b required raw %h", rnd, c, raw_clear, wb_en, exp);
            end
         end
         ld = 1'($urandom); maddr = $urandom; mdata = $urandom; rdata = $urandom;
         mdes = 4'($urandom); dly = $urandom_range(0, 3);
         clear_in();
         i_vld[0] = 1'b1; i_des[0] = mdes; i_data[0] = mdata; in_mem_addr = maddr;
         in_load_flag = ld; in_store_flag = !ld || 1'($urandom);
         rand_alu_lanes(1, mdes, 1'b1);
         model_step(exp);
         tick();
         reqc = 0; dones = 0; ldw = 0;
         for (int c = 0; c < 16 && dones == 0; c++) begin
            clear_in();
            rand_alu_lanes(1, mdes, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
               i_vld[0] = 1'b1; in_store_flag = 1'b1; in_mem_addr = ~maddr; i_des[0] = 4'($urandom); i_data[0] = $urandom;
            end
            if (dmem_req === 1'b1) begin
               reqc++;
               ncmp++;
               if (dmem_addr !== maddr || dmem_we !== !ld || (!ld && dmem_wdata !== mdata)) begin
                  nerr++; $display("FAIL rand_req r%0d: addr=%h we=%b wdata=%h required %h/%b/%h",
                                   rnd, dmem_addr, dmem_we, dmem_wdata, maddr, !ld, mdata);
               end
               dmem_ack = (reqc == dly + 1);
               dmem_rdata = (reqc == dly + 1) ? rdata : $urandom;
            end
            model_step(exp);
            tick();
            dones += int'(mem_in_done === 1'b1);
            ldw += int'(raw_clear[mdes] === 1'b1);
            ncmp++;
            if ((raw_clear & ~(16'h1 << mdes)) !== exp) begin
               nerr++; $display("FAIL rand_mem_raw r%0d c%0d: raw=%h required %h (+load bit)", rnd, c, raw_clear, exp);
            end
         end
         if (ld) mrf[mdes] = rdata;
         ncmp++;
         if (dones != 1 || reqc != dly + 1 || ldw != int'(ld)) begin
            nerr++; $display("FAIL rand_mem_seq r%0d: done=%0d req=%0d loadwr=%0d required 1/%0d/%0d",
                             rnd, dones, reqc, ldw, dly + 1, int'(ld));
         end
         diff = 0;
         for (int r = 0; r < 16; r++) diff += int'(rf_dut[r] !== mrf[r]);
         ncmp++;
         if (diff != 0) begin nerr++; $display("FAIL rand_regfile r%0d: %0d registers differ required 0", rnd, diff); end
      end
      clear_in();
      tick();
   endtask

   initial begin
      for (int r = 0; r < 16; r++) begin rf_dut[r] = '0; mrf[r] = '0; end
      clear_in();
      test_reset();
      test_alu_burst();
      test_collision();
      test_load();
      test_store();
      test_ldwb_stall(1'b0);
      test_ldwb_stall(1'b1);
      test_reset_mid_req();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1);
   end
endmodule
